next_pc_unit: RTL
=================

# next_pc_unit

Program-counter stage that takes the 26-bit jump-target field and turns it into the next fetch address. It holds the architectural PC register and selects the next PC: sequential, conditional branch, jump, or jump-register. It also provides stall and halt control, detects misaligned jump-register targets, and counts retired PC updates. It sits between the decode-side field buffers and instruction fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- COUNT_WIDTH, 32, width of the retired-update counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- jump_target  in  26  instruction jump-target field (instr[25:0]).
- branch_offset  in  16  branch immediate, in words, signed.
- pc_sel  in  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- branch_taken  in  1  branch condition result; only used when pc_sel=01.
- jr_addr  in  32  jump-register target.
- stall  in  1  hold the PC this cycle.
- halt_req  in  1  request a permanent halt.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc+4 (combinational from pc).
- halted  out  1  high in HALT state.
- align_err  out  1  sticky flag: misaligned jump-register target caused the halt.
- retired_count  out  COUNT_WIDTH  number of PC updates since reset.

## Operation
- Arithmetic is modulo 2^32. No overflow detection.
- pc_plus4 = pc + 4. Target values:
  - sequential = pc_plus4
  - branch = pc_plus4 + (sign_extend(branch_offset) << 2) when branch_taken=1; otherwise pc_plus4
  - jump = {pc_plus4[31:28], jump_target, 2'b00}
  - jump-register = jr_addr
- FSM states: RUN and HALT. Reset enters RUN.
- In RUN, each cycle resolves in this priority order:
  1. halt_req=1: pc holds, next state is HALT, counter holds.
  2. stall=1: pc holds, counter holds, stay in RUN. pc_sel is ignored, so no misalignment check is made.
  3. pc_sel=11 and jr_addr[1:0]≠0: pc holds, align_err is set to 1, next state is HALT, counter holds.
  4. Otherwise: pc loads the selected target and retired_count increments, wrapping at 2^COUNT_WIDTH.
- In HALT, all inputs are ignored; pc, retired_count and align_err are frozen and halted=1. Only rst_n leaves HALT.
- A not-taken branch still counts as an update: pc goes to pc_plus4 and the counter increments.
- Once set, align_err stays at 1 until reset.

## Timing
- Reset values (asserted immediately when rst_n falls, independent of clk): pc=RESET_PC, pc_plus4=RESET_PC+4, halted=0, align_err=0, retired_count=0, state=RUN.
- Reset mid-operation discards any pending update. The first update after rst_n rises happens on the first rising clk edge that has rst_n=1.
- Latency: the selected target appears on pc one cycle after the inputs are sampled. pc_plus4 follows pc in the same cycle.
- halted and align_err go high on the same edge that enters HALT.
- retired_count changes on the same edge as pc.
- All inputs are sampled only on the rising clk edge; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and sequential run: RESET_PC=0x0000_0100; release reset, run 3 sequential cycles -> pc steps 0x104, 0x108, 0x10C; retired_count=3. Drive rst_n low mid-cycle -> pc=0x100 and count=0 immediately, without waiting for a clk edge.
- Jump: pc=0x4000_0010, pc_sel=10, jump_target=26'h000_0100 -> pc=0x4000_0400 next cycle.
- Branch: pc=0x100, pc_sel=01, offset=16'hFFFF, taken=1 -> pc=0x100. Same inputs with taken=0 -> pc=0x104. Both cases increment the count.
- Jump-register alignment:
  - jr_addr=0x0000_2000 -> pc=0x2000.
  - jr_addr=0x0000_1002 -> pc unchanged, align_err=1, halted=1; further inputs have no effect.
  - Same misaligned jr_addr with stall=1 -> no error; pc holds.
- Priority and halt: halt_req=1 and stall=1 with pc_sel=10 in the same cycle -> HALT with align_err=0 and pc unchanged; only reset recovers.
- Wrap-around: pc=0xFFFF_FFFC sequential -> pc=0x0000_0000, pc_plus4=0x4. With COUNT_WIDTH=4 and 16 updates -> retired_count returns to 0.

Source files
------------

// File: rtl/next_pc_unit.sv
// Program-counter stage: holds the architectural PC, selects the next fetch
// address, and provides stall/halt control with a retired-update counter.
module next_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [25:0]            jump_target,
    input  logic [15:0]            branch_offset,
    input  logic [1:0]             pc_sel,
    input  logic                   branch_taken,
    input  logic [31:0]            jr_addr,
    input  logic                   stall,
    input  logic                   halt_req,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   halted,
    output logic                   align_err,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] branch_disp;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    assign pc_plus4      = pc + 32'd4;
    assign branch_disp   = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign jr_misaligned = (pc_sel == 2'b11) && (jr_addr[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        unique case (pc_sel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = branch_taken ? (pc_plus4 + branch_disp) : pc_plus4;
            2'b10: next_pc = {pc_plus4[31:28], jump_target, 2'b00};
            2'b11: next_pc = jr_addr;
            default: next_pc = pc_plus4;
        endcase
    end

    // Priority within RUN: halt request, then stall, then misaligned jr, then update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            halted        <= 1'b0;
            align_err     <= 1'b0;
            retired_count <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (stall) begin
                        state <= RUN;
                    end else if (jr_misaligned) begin
                        state     <= HALT;
                        halted    <= 1'b1;
                        align_err <= 1'b1;
                    end else begin
                        pc            <= next_pc;
                        retired_count <= retired_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule
